mult_div_unit: RTL

Multicycle signed multiply/divide unit for the MIPS multicycle datapath, acting as the responder to the control unit. The control unit pulses a start request with operands on A/B. The unit iterates for 32 cycles and writes the 64-bit product, or the quotient/remainder, into its internal HI/LO registers. It then pulses `done`. On a zero divisor it returns the `div_zero` flag, which the control unit consumes for its exception path.

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed 32x32 multiply / divide unit. A start in IDLE latches
//   the operands, the unit iterates for 32 cycles, writes HI/LO and then
//   pulses done. A divide with a zero divisor pulses div_zero instead.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   mult_start, div_start  requests, sampled only in IDLE (multiply wins)
//   A, B                   operands, latched on the accepting edge
//   HI, LO                 product[63:32]/[31:0] or remainder/quotient
//   busy                   high while iterating
//   done                   one-cycle pulse with a new HI/LO result
//   div_zero               one-cycle pulse on divide with B == 0
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DZERO = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [31:0] a_reg, b_reg;
  // Shared iteration registers: Booth accumulator : multiplier for MULT,
  // partial remainder : dividend/quotient shift register for DIV.
  logic [33:0] acc_hi;
  logic [31:0] acc_lo;
  logic        q_1;

  // Booth radix-2 step. The accumulator carries two guard bits so that
  // adding/subtracting -2^31 never overflows before the arithmetic shift.
  logic [33:0] a_ext, m_sum, m_hi_nx;
  logic [31:0] m_lo_nx;

  always_comb begin
    a_ext = {{2{a_reg[31]}}, a_reg};
    case ({acc_lo[0], q_1})
      2'b01:   m_sum = acc_hi + a_ext;
      2'b10:   m_sum = acc_hi - a_ext;
      default: m_sum = acc_hi;
    endcase
    m_hi_nx = {m_sum[33], m_sum[33:1]};
    m_lo_nx = {m_sum[0], acc_lo[31:1]};
  end

  // Restoring division step on magnitudes. |-2^31| = 2^31 is representable
  // as an unsigned 32-bit value, so no special case is needed.
  logic [31:0] a_mag, b_mag;
  logic [32:0] d_shift, d_trial, d_hi_nx;
  logic [31:0] d_lo_nx, quo_s, rem_s;

  always_comb begin
    a_mag   = A[31] ? -A : A;
    b_mag   = b_reg[31] ? -b_reg : b_reg;
    d_shift = {acc_hi[31:0], acc_lo[31]};
    d_trial = d_shift - {1'b0, b_mag};
    d_hi_nx = d_trial[32] ? d_shift : d_trial;
    d_lo_nx = {acc_lo[30:0], ~d_trial[32]};
    // Quotient truncates toward zero, remainder follows the dividend sign.
    // -2^31 / -1 negates 2^31 back to 0x80000000 (wraps).
    quo_s   = (a_reg[31] ^ b_reg[31]) ? -d_lo_nx : d_lo_nx;
    rem_s   = a_reg[31] ? -d_hi_nx[31:0] : d_hi_nx[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      q_1      <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            a_reg  <= A;
            b_reg  <= B;
            acc_hi <= '0;
            acc_lo <= B;
            q_1    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MULT;
          end else if (div_start) begin
            if (B != 32'd0) begin
              a_reg  <= A;
              b_reg  <= B;
              acc_hi <= '0;
              acc_lo <= a_mag;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= DIV;
            end else begin
              div_zero <= 1'b1;
              state    <= DZERO;
            end
          end
        end
        MULT: begin
          acc_hi <= m_hi_nx;
          acc_lo <= m_lo_nx;
          q_1    <= acc_lo[0];
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            HI    <= m_hi_nx[31:0];
            LO    <= m_lo_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          acc_hi <= {1'b0, d_hi_nx};
          acc_lo <= d_lo_nx;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            HI    <= rem_s;
            LO    <= quo_s;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        DZERO:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
